// File: rtl/armleocpu_fifo_sync_pkg.sv
// Shared types for the block-RAM backed synchronous FIFO.
// The output stage state is the only FSM; its encoding doubles as out_valid.
package armleocpu_fifo_sync_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/armleocpu_fifo_sync_mem_1w1r.sv
// One-write/one-read synchronous RAM: read data is registered on the read strobe
// and holds its value otherwise, so it can directly drive a FIFO head register.
module armleocpu_mem_1w1r #(
  parameter int ELEMENTS_W = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  read_i,
  input  logic [ELEMENTS_W-1:0] readaddress_i,
  output logic [WIDTH-1:0]      readdata_o,
  input  logic                  write_i,
  input  logic [ELEMENTS_W-1:0] writeaddress_i,
  input  logic [WIDTH-1:0]      writedata_i
);

  logic [WIDTH-1:0] storage_q [2**ELEMENTS_W];
  logic [WIDTH-1:0] readdata_q;

  // No reset: contents and read register are don't-care until written/fetched.
  always_ff @(posedge clk) begin
    if (write_i) storage_q[writeaddress_i] <= writedata_i;
    if (read_i)  readdata_q <= storage_q[readaddress_i];
  end

  assign readdata_o = readdata_q;

endmodule

// File: rtl/armleocpu_fifo_sync.sv
// Valid/ready FIFO over a synchronous RAM with a first-word-fall-through head.
// Capacity is 2**DEPTH_W words in RAM plus one held in the RAM read register.
module armleocpu_fifo_sync
  import armleocpu_fifo_sync_pkg::*;
#(
  parameter int DEPTH_W = 4,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [DEPTH_W:0]   count
);

  localparam int CNT_W = DEPTH_W + 1;
  localparam logic [CNT_W-1:0] ELEMENTS = CNT_W'(2**DEPTH_W);

  // Valid/ready: a transfer happens on a rising edge where valid & ready are both
  // high; ready never depends combinationally on valid.
  logic [DEPTH_W-1:0] wptr_q, wptr_d;
  logic [DEPTH_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
  out_state_t         out_state_q, out_state_d;

  logic push, pop, fetch;

  assign out_valid = (out_state_q == OUT_VALID);
  assign in_ready  = rst_n & (mem_cnt_q != ELEMENTS);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Prefetch whenever the head register is free or being consumed this cycle.
  assign fetch     = (mem_cnt_q != '0) & (!out_valid | out_ready);
  assign count     = mem_cnt_q + CNT_W'(out_valid);

  always_comb begin
    wptr_d      = wptr_q + DEPTH_W'(push);
    rptr_d      = rptr_q + DEPTH_W'(fetch);
    mem_cnt_d   = mem_cnt_q + CNT_W'(push) - CNT_W'(fetch);
    out_state_d = out_state_q;
    case (out_state_q)
      OUT_EMPTY: if (fetch) out_state_d = OUT_VALID;
      OUT_VALID: if (pop && !fetch) out_state_d = OUT_EMPTY;
      default:   out_state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_cnt_q   <= '0;
      out_state_q <= OUT_EMPTY;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_state_q <= out_state_d;
    end
  end

  // Read and write addresses can never collide: a read needs mem_cnt != 0 and a
  // write needs mem_cnt != ELEMENTS, and rptr == wptr only at one of those.
  armleocpu_mem_1w1r #(
    .ELEMENTS_W (DEPTH_W),
    .WIDTH      (WIDTH)
  ) u_mem (
    .clk            (clk),
    .read_i         (fetch),
    .readaddress_i  (rptr_q),
    .readdata_o     (out_data),
    .write_i        (push),
    .writeaddress_i (wptr_q),
    .writedata_i    (in_data)
  );

endmodule

// File: tb/tb_armleocpu_fifo_sync.sv
// Self-checking bench for armleocpu_fifo_sync (DEPTH_W=2, WIDTH=8, capacity 5)
// against a queue-based reference model.
module tb_armleocpu_fifo_sync;

  localparam int DEPTH_W  = 2;
  localparam int WIDTH    = 8;
  localparam int CAPACITY = 2**DEPTH_W + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH_W:0] count;

  armleocpu_fifo_sync #(.DEPTH_W(DEPTH_W), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every accepted word, oldest first
  logic [WIDTH-1:0] exp_q[$];
  bit               exp_ov;
  int               n_checks;
  int               n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The head word is not visible until it has been stored for one full cycle,
  // so in_ready is judged on words held outside the output position.
  function automatic bit exp_ready();
    return (exp_q.size() - int'(exp_ov)) != (CAPACITY - 1);
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready()));
    if (exp_ov) check_val({tag, "_out_data"}, 32'(out_data), 32'(exp_q[0]));
  endtask

  // One clock: check the state after the previous edge, drive, then advance the model.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    bit push, pop;
    int older;
    @(negedge clk);
    check_outputs("cyc");
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    push = iv && exp_ready();
    pop  = exp_ov && ordy;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    older = exp_q.size();
    if (push) exp_q.push_back(id);
    exp_ov = (older > 0);
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (edges) @(posedge clk);
    exp_q.delete();
    exp_ov = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready_low", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready_release", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    repeat (CAPACITY + 3) cycle(1'b0, '0, 1'b1);
    @(negedge clk);
    check_val("drain_empty", 32'(count), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_ov    = 1'b0;
    do_reset(2);

    // single word fall-through
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check_val("single_cnt_e0", 32'(count), 32'd1);
    check_val("single_ov_e0", 32'(out_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check_val("single_ov_e1", 32'(out_valid), 32'd1);
    check_val("single_data_e1", 32'(out_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b0);
    check_val("single_ov_pop", 32'(out_valid), 32'd0);
    check_val("single_cnt_pop", 32'(count), 32'd0);

    // fill past capacity with the consumer stalled
    for (int i = 1; i <= 6; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check_val("fill_count", 32'(count), 32'd5);
    check_val("fill_in_ready", 32'(in_ready), 32'd0);
    check_val("fill_head", 32'(out_data), 32'h01);
    drain();

    // streaming through pointer wraps
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b1);
      check_val("stream_cnt_le2", 32'(count <= 2), 32'd1);
    end
    drain();

    // backpressure 1,0,0,1
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h40 + i), 1'b0);
    for (int i = 0; i < 16; i++)
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), (i % 4 == 0) || (i % 4 == 3));
    drain();

    // reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h70 + i), 1'b0);
    do_reset(1);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_val("rst_mid_head", 32'(out_data), 32'h3C);
    drain();

    // random traffic
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
